// File: rtl/fir_pkg.sv
// Shared FIR datapath types: operand width,
// multiplier FSM states and Booth op codes.
package fir_pkg;

  localparam int W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    NOP = 2'd0,
    ADD = 2'd1,
    SUB = 2'd2
  } booth_op_t;

  function automatic booth_op_t booth_op(
    input logic q0,
    input logic q_1
  );
    booth_op_t op;
    unique case ({q0, q_1})
      2'b01:   op = ADD;
      2'b10:   op = SUB;
      default: op = NOP;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: add/sub
// then arithmetic shift of {A,Q,Q_1}.
module booth_step
  import fir_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic [W:0]   a,
  input  logic [W-1:0] q,
  input  logic         q_1,
  input  logic [W:0]   m,
  output logic [W:0]   a_nxt,
  output logic [W-1:0] q_nxt,
  output logic         q_1_nxt
);

  booth_op_t  op;
  logic [W:0] sum;

  always_comb begin
    op  = booth_op(q[0], q_1);
    sum = a;
    unique case (op)
      ADD:     sum = a + m;
      SUB:     sum = a - m;
      default: sum = a;
    endcase
    a_nxt   = {sum[W], sum[W:1]};
    q_nxt   = {sum[0], q[W-1:1]};
    q_1_nxt = q[0];
  end

endmodule

// File: rtl/booth_mult_seq.sv
// Sequential signed Booth multiplier,
// one iteration per clock, start/busy/done.
module booth_mult_seq
  import fir_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int CNT_W = 3
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           start,
  input  logic [W-1:0]   mcand,
  input  logic [W-1:0]   mplier,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] product
);

  state_t           state;
  state_t           state_nxt;
  logic [W:0]       a;
  logic [W-1:0]     q;
  logic             q_1;
  logic [W:0]       m;
  logic [CNT_W-1:0] count;
  logic [W:0]       a_nxt;
  logic [W-1:0]     q_nxt;
  logic             q_1_nxt;
  logic             accept;
  logic             last;

  booth_step #(.W(W)) u_step (
    .a       (a),
    .q       (q),
    .q_1     (q_1),
    .m       (m),
    .a_nxt   (a_nxt),
    .q_nxt   (q_nxt),
    .q_1_nxt (q_1_nxt)
  );

  always_comb begin
    accept = start &&
             (state == IDLE ||
              state == DONE);
    last   = (state == RUN) &&
             (count == CNT_W'(1));
    busy   = (state == RUN);
    done   = (state == DONE);
  end

  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE:    state_nxt = start ? RUN : IDLE;
      RUN:     state_nxt = last ? DONE : RUN;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      a       <= '0;
      q       <= '0;
      q_1     <= 1'b0;
      m       <= '0;
      count   <= '0;
      product <= '0;
    end else begin
      unique case (1'b1)
        accept: begin
          m     <= {mcand[W-1], mcand};
          a     <= '0;
          q     <= mplier;
          q_1   <= 1'b0;
          count <= CNT_W'(W);
        end
        busy: begin
          a     <= a_nxt;
          q     <= q_nxt;
          q_1   <= q_1_nxt;
          count <= count - CNT_W'(1);
          if (last) begin
            product <= {a_nxt[W-1:0], q_nxt};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mult_seq.sv
// Self-checking bench for booth_mult_seq
// against a plain-arithmetic product model.
module tb_booth_mult_seq;

  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rstn = 1'b0;
  logic           start = 1'b0;
  logic [W-1:0]   mcand = '0;
  logic [W-1:0]   mplier = '0;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;

  int n_checks = 0;
  int n_pass   = 0;

  booth_mult_seq #(.W(W), .CNT_W(3)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .start   (start),
    .mcand   (mcand),
    .mplier  (mplier),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  always #5 clk = ~clk;

  task automatic check(
    input string  tag,
    input longint got,
    input longint exp
  );
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  tag, got, exp);
  endtask

  function automatic logic [2*W-1:0] ref_mul(
    input logic [W-1:0] x,
    input logic [W-1:0] y
  );
    int sx;
    int sy;
    int p;
    sx = $signed(x);
    sy = $signed(y);
    p  = sx * sy;
    return (2*W)'(p);
  endfunction

  // accept one op; optionally poke start
  // with other operands mid-run
  task automatic run_op(
    input logic [W-1:0] x,
    input logic [W-1:0] y,
    input bit           poke,
    input bit           full
  );
    int n;
    int nbusy;
    logic [2*W-1:0] exp;
    exp = ref_mul(x, y);
    @(negedge clk);
    start  = 1'b1;
    mcand  = x;
    mplier = y;
    @(posedge clk);
    @(negedge clk);
    start  = 1'b0;
    mcand  = ~x;
    mplier = y + 4'd3;
    n = 0;
    nbusy = 0;
    while (!done && n < 20) begin
      if (busy) nbusy++;
      if (poke && n == 1) begin
        start  = 1'b1;
        mcand  = 4'd7;
        mplier = 4'd5;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    check("product", longint'(product), longint'(exp));
    if (full) begin
      check("latency", n, 4);
      check("busy_cycles", nbusy, 4);
      check("busy_at_done", longint'(busy), 0);
    end
  endtask

  initial begin
    int t_done[$];
    logic [2*W-1:0] exp_q[$];
    int cyc;
    int ndone;
    int nwrong;

    #12;
    check("rst_busy", longint'(busy), 0);
    check("rst_done", longint'(done), 0);
    check("rst_product", longint'(product), 0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    run_op(4'd3, 4'hE, 1'b0, 1'b1);
    check("fa_const", longint'(product), 64'hFA);
    @(negedge clk);
    check("done_pulse", longint'(done), 0);
    repeat (3) @(negedge clk);
    check("hold", longint'(product), 64'hFA);

    run_op(4'h8, 4'h8, 1'b0, 1'b1);
    check("p64", longint'(product), 64'h40);
    run_op(4'h8, 4'h7, 1'b0, 1'b1);
    check("m56", longint'(product), 64'hC8);
    run_op(4'h7, 4'h7, 1'b0, 1'b1);
    check("p49", longint'(product), 64'h31);

    // back-to-back with start held high
    @(negedge clk);
    start  = 1'b1;
    mcand  = 4'd2;
    mplier = 4'd4;
    exp_q.push_back(8'h08);
    exp_q.push_back(8'hFC);
    ndone = 0;
    for (cyc = 0; cyc < 16; cyc++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        t_done.push_back(cyc);
        if (exp_q.size() != 0)
          check("b2b_product", longint'(product),
                longint'(exp_q.pop_front()));
        mcand  = 4'hF;
        mplier = 4'd4;
        if (ndone >= 2) start = 1'b0;
      end
    end
    start = 1'b0;
    check("b2b_count", ndone, 2);
    if (t_done.size() == 2)
      check("b2b_space", t_done[1] - t_done[0], 5);

    run_op(4'd6, 4'd5, 1'b1, 1'b1);
    check("ignore_mid", longint'(product), 64'h1E);
    repeat (8) @(negedge clk);
    check("no_queue", longint'(busy), 0);

    // reset during iteration 2
    @(negedge clk);
    start  = 1'b1;
    mcand  = 4'd5;
    mplier = 4'd3;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #2;
    rstn = 1'b0;
    #1;
    check("abort_busy", longint'(busy), 0);
    check("abort_done", longint'(done), 0);
    check("abort_product", longint'(product), 0);
    @(negedge clk);
    rstn = 1'b1;
    nwrong = 0;
    repeat (8) begin
      @(negedge clk);
      if (done || busy) nwrong++;
    end
    check("no_done_after_rst", nwrong, 0);
    run_op(4'd5, 4'd3, 1'b0, 1'b1);
    check("after_rst", longint'(product), 64'h0F);

    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++)
        run_op(W'(i), W'(j), 1'b0, 1'b1);

    for (int k = 0; k < 40; k++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_op(W'($urandom), W'($urandom),
             1'($urandom), 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/booth_mult_seq.md
Name: booth_mult_seq

Overview:
- Sequential radix-2 Booth multiplier: one signed sample × one signed coefficient, one Booth iteration per clock.
- Sits directly upstream of the FIR tap-sum/normalise stage and supplies its tap products, replacing the combinational `*` operators.
- Uses a start/busy/done handshake so one instance can be time-shared across taps by a tap sequencer.

Parameters:
- W, 4, operand width in bits (signed, two's complement); product width is 2W.
- CNT_W, 3, iteration counter width; must satisfy 2^CNT_W > W.

Ports:
- clk  input  1  rising-edge clock
- rstn  input  1  asynchronous active-low reset; asserts immediately, deasserts synchronously to clk
- start  input  1  request; sampled only in IDLE or DONE
- mcand  input  W  signed multiplicand (sample); latched on accepted start
- mplier  input  W  signed multiplier (coefficient); latched on accepted start
- busy  output  1  high while iterating (RUN)
- done  output  1  single-cycle pulse; product valid and newly updated
- product  output  2W  signed product; holds last result until next completion

Behaviour:
- Reset (rstn=0, asynchronous):
  - state=IDLE; busy=0; done=0; product=0.
  - Internal A=0, Q=0, Q_1=0, M=0, count=0.
  - Reset during RUN aborts the operation: no done pulse, product stays 0, and start must be re-asserted after reset.
- States: IDLE, RUN, DONE.
  - IDLE → RUN on start=1.
  - RUN → RUN while count≠1; RUN → DONE on the iteration where count==1.
  - DONE → RUN if start=1 (back-to-back accepted); otherwise DONE → IDLE.
- Accept edge E0 (start=1 in IDLE or DONE):
  - M ← sign-extend(mcand) to W+1 bits.
  - A ← 0 (W+1 bits); Q ← mplier; Q_1 ← 0; count ← W.
  - busy=1 from E0.
- Iteration edges E1..EW (one per clock in RUN):
  - {Q[0],Q_1} = 01 → A ← A + M.
  - {Q[0],Q_1} = 10 → A ← A − M.
  - {Q[0],Q_1} = 00 or 11 → A unchanged.
  - Then arithmetic right shift of {A,Q,Q_1} by 1; A's MSB replicates.
  - count ← count − 1.
- Completion at edge EW:
  - state ← DONE; product ← lower 2W bits of {A,Q} after the final shift.
  - done=1 and busy=0 in the cycle after EW.
  - Latency: W clock edges from accept to done visible (4 for the default).
- done is high for exactly one cycle per completed operation, including back-to-back operations.
- start while busy is ignored: operands are not relatched and no queueing occurs.
- mcand and mplier may change freely after the accept edge.
- Width rules:
  - A is W+1 bits, so A−M cannot overflow when mcand = −2^(W−1).
  - The product always fits 2W signed bits; (−8)×(−8)=+64 is representable.
  - No saturation or rounding; exact two's-complement result.
- Zero operand: still takes the full W iterations; product=0, done pulses normally.

Decomposition:
- Shared package fir_pkg:
  - W default.
  - State encoding: IDLE=2'd0, RUN=2'd1, DONE=2'd2; 2'd3 is illegal and recovers to IDLE.
  - Booth op encoding: NOP, ADD, SUB.
- Sub-module booth_step: purely combinational single iteration.
  - Inputs: A, Q, Q_1, M.
  - Outputs: next A, Q, Q_1.
  - booth_mult_seq instantiates it once and owns all registers, the FSM and the counter.

Test Plan:
- Reset, then start with mcand=3, mplier=−2 → busy high 4 cycles; done pulses once; product=8'hFA (−6); product holds afterwards.
- mcand=−8, mplier=−8 → product=8'h40 (+64). Then mcand=−8, mplier=7 → 8'hC8 (−56). Then 7×7 → 8'h31 (49).
- Hold start=1 continuously with new operands each DONE cycle (2×4 then −1×4) → done pulses each spaced by 5 cycles; products 8'h08 then 8'hFC; no lost or duplicated done.
- Assert start mid-RUN with different operands → ignored; result matches the originally latched operands.
- Drop rstn during iteration 2 of 5×3 → busy, done and product go to 0 immediately; no done after release; a fresh start of 5×3 gives 8'h0F.
- Exhaustive sweep of all 256 operand pairs against a reference model → every product exact; latency always 4.
